// File: rtl/gray2bin_sync_pkg.sv
// Shared Gray-code helpers and FSM state type for the Gray count link (encoder and decoder side).
// Latency: n/a (functions and types only).
// Backpressure: n/a.
package gray2bin_sync_pkg;

    localparam int FN_W = 32;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Narrower words are zero-extended by the caller; leading zeros do not disturb the low bits.
    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b[FN_W-1] = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] popcount(input logic [FN_W-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < FN_W; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sync_nff.sv
// Plain multi-bit flop synchronizer; no logic between stages.
// Latency: STAGES clk edges from input to sync_dat.
// Backpressure: none, samples every cycle.
module sync_nff #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_dat,
    output logic [WIDTH-1:0] sync_dat
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], async_dat};
        end
    end

    assign sync_dat = stage_q[STAGES-1];

endmodule

// File: rtl/gray2bin_sync.sv
// Gray count link receiver: synchronize, decode to binary, classify each change as up/down/err.
// Latency: SYNC_STAGES+1 clk edges from a stable gray_in change to the valid pulse.
// Backpressure: none; valid/up/down/err are single-cycle pulses that the consumer must take.
module gray2bin_sync
    import gray2bin_sync_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     binario,
    output logic                 valid,
    output logic                 up,
    output logic                 down,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 locked
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic [WIDTH-1:0]     g_s;
    logic [WIDTH-1:0]     g_prev_q;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     d;
    state_t               state_q;
    state_t               state_nxt;
    logic [CNT_W-1:0]     init_cnt_q;
    logic [CNT_W-1:0]     init_cnt_nxt;
    logic [WIDTH-1:0]     g_prev_nxt;
    logic [WIDTH-1:0]     binario_nxt;
    logic                 valid_nxt;
    logic                 up_nxt;
    logic                 down_nxt;
    logic                 err_nxt;
    logic [ERR_CNT_W-1:0] err_cnt_nxt;
    logic                 locked_nxt;

    sync_nff #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_dat (gray_in),
        .sync_dat  (g_s)
    );

    assign b = WIDTH'(gray2bin(FN_W'(g_s)));
    assign d = g_s ^ g_prev_q;

    always_comb begin
        state_nxt    = state_q;
        init_cnt_nxt = init_cnt_q;
        g_prev_nxt   = g_s;
        binario_nxt  = binario;
        valid_nxt    = 1'b0;
        up_nxt       = 1'b0;
        down_nxt     = 1'b0;
        err_nxt      = 1'b0;
        err_cnt_nxt  = err_cnt;
        locked_nxt   = locked;

        case (state_q)
            ST_INIT: begin
                // Wait until the chain holds a real sample, then adopt it silently.
                if (init_cnt_q == CNT_W'(SYNC_STAGES)) begin
                    state_nxt   = ST_TRACK;
                    binario_nxt = b;
                    locked_nxt  = 1'b1;
                end else begin
                    init_cnt_nxt = init_cnt_q + CNT_W'(1);
                end
            end
            ST_TRACK: begin
                // Clear first so a same-cycle err still counts once.
                if (clr_err) begin
                    err_cnt_nxt = '0;
                end
                if (popcount(FN_W'(d)) == 6'd1) begin
                    binario_nxt = b;
                    valid_nxt   = 1'b1;
                    if (b == binario + WIDTH'(1)) begin
                        up_nxt = 1'b1;
                    end else begin
                        down_nxt = 1'b1;
                    end
                end else if (d != '0) begin
                    binario_nxt = b;
                    valid_nxt   = 1'b1;
                    err_nxt     = 1'b1;
                    if (err_cnt_nxt != ERR_MAX) begin
                        err_cnt_nxt = err_cnt_nxt + ERR_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            g_prev_q   <= '0;
            binario    <= '0;
            valid      <= 1'b0;
            up         <= 1'b0;
            down       <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
            locked     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            init_cnt_q <= init_cnt_nxt;
            g_prev_q   <= g_prev_nxt;
            binario    <= binario_nxt;
            valid      <= valid_nxt;
            up         <= up_nxt;
            down       <= down_nxt;
            err        <= err_nxt;
            err_cnt    <= err_cnt_nxt;
            locked     <= locked_nxt;
        end
    end

endmodule

// File: tb/tb_gray2bin_sync.sv
// Randomized scoreboard bench for gray2bin_sync with a plain-arithmetic reference model.
module tb_gray2bin_sync;

    localparam int WIDTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int ERR_CNT_W   = 8;
    localparam int CNT_MAX     = (1 << ERR_CNT_W) - 1;
    localparam int MOD         = 1 << WIDTH;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [WIDTH-1:0]     gray_in;
    logic                 clr_err;
    logic [WIDTH-1:0]     binario;
    logic                 valid;
    logic                 up;
    logic                 down;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 locked;

    gray2bin_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .ERR_CNT_W   (ERR_CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .gray_in (gray_in),
        .clr_err (clr_err),
        .binario (binario),
        .valid   (valid),
        .up      (up),
        .down    (down),
        .err     (err),
        .err_cnt (err_cnt),
        .locked  (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bin;
        bit up;
        bit down;
        bit err;
        int cnt;
    } exp_t;

    exp_t           exp_q[$];
    int             n_vec = 0;
    int             n_fail = 0;
    int             model_b;
    int             model_cnt;
    logic [WIDTH-1:0] cur_g;

    // Binary value of a Gray word: XOR of all its right shifts.
    function automatic int g2b(input logic [WIDTH-1:0] g);
        int r = 0;
        for (int s = 0; s < WIDTH; s++) r ^= int'(g) >> s;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] b2g(input int v);
        int m = v % MOD;
        return WIDTH'(m ^ (m >> 1));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Predict the pulse a new gray_in value will produce and queue it.
    task automatic push_exp(input logic [WIDTH-1:0] g, input bit clr);
        int   nb = g2b(g);
        int   hd = $countones(g ^ cur_g);
        exp_t e;
        if (hd != 0) begin
            e.bin  = nb;
            e.err  = (hd > 1);
            e.up   = !e.err && (((nb - model_b) & (MOD - 1)) == 1);
            e.down = !e.err && !e.up;
            if (clr) model_cnt = e.err ? 1 : 0;
            else if (e.err && model_cnt < CNT_MAX) model_cnt++;
            e.cnt = model_cnt;
            exp_q.push_back(e);
        end else if (clr) begin
            model_cnt = 0;
        end
        cur_g   = g;
        model_b = nb;
    endtask

    // Called at a negedge; returns at a negedge 4 cycles later. clr lands on the decode cycle.
    task automatic apply(input logic [WIDTH-1:0] g, input bit clr);
        push_exp(g, clr);
        gray_in = g;
        @(negedge clk);
        @(negedge clk);
        clr_err = clr;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    // Change gray_in, let it get one flop deep, then reset and watch re-lock.
    task automatic do_reset(input logic [WIDTH-1:0] g);
        @(negedge clk);
        gray_in = g;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("reset_outputs_zero",
                 64'({binario, valid, up, down, err, err_cnt, locked}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("locked_before_init_done", 64'(locked), 64'd0);
        @(negedge clk);
        check("locked_after_init", 64'(locked), 64'd1);
        check("binario_after_init", 64'(binario), 64'(g2b(g)));
        cur_g     = g;
        model_b   = g2b(g);
        model_cnt = 0;
    endtask

    // Monitor: every valid pulse must match the oldest queued prediction.
    always @(negedge clk) begin
        exp_t e;
        if (valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                n_vec++;
                if (int'(binario) != e.bin || up != e.up || down != e.down ||
                    err != e.err || int'(err_cnt) != e.cnt) begin
                    n_fail++;
                    $display("FAIL scoreboard: got bin=%0d up=%0b down=%0b err=%0b cnt=%0d, expected bin=%0d up=%0b down=%0b err=%0b cnt=%0d",
                             binario, up, down, err, err_cnt, e.bin, e.up, e.down, e.err, e.cnt);
                end
            end
        end else if (up || down || err) begin
            check("flags_without_valid", 64'({up, down, err}), 64'd0);
        end
    end

    initial begin
        bit seen;
        logic [WIDTH-1:0] g;
        rst_n   = 1'b1;
        gray_in = '0;
        clr_err = 1'b0;
        cur_g   = '0;
        model_b = 0;
        model_cnt = 0;
        #1 rst_n = 1'b0;

        do_reset(4'b0110);
        do_reset(4'b0000);

        for (int v = 1; v <= MOD; v++) apply(b2g(v), 1'b0);
        check("fwd_err_cnt", 64'(err_cnt), 64'd0);
        check("fwd_final_bin", 64'(binario), 64'd0);

        for (int v = MOD - 1; v >= 0; v--) apply(b2g(v), 1'b0);
        check("rev_err_cnt", 64'(err_cnt), 64'd0);

        apply(4'b0011, 1'b0);
        check("jump_err_cnt", 64'(err_cnt), 64'd1);
        for (int i = 0; i < 300; i++) apply((i % 2 == 0) ? 4'b0000 : 4'b0011, 1'b0);
        check("err_cnt_saturated", 64'(err_cnt), 64'(CNT_MAX));
        apply((cur_g == 4'b0000) ? 4'b0011 : 4'b0000, 1'b1);
        check("clr_with_err", 64'(err_cnt), 64'd1);
        apply(cur_g, 1'b1);
        check("clr_alone", 64'(err_cnt), 64'd0);

        g = b2g(model_b + 1);
        push_exp(g, 1'b0);
        gray_in = g;
        for (int i = 1; i <= SYNC_STAGES + 1; i++) begin
            @(negedge clk);
            check("latency_valid_edge", 64'(valid), 64'(i == SYNC_STAGES + 1));
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= valid;
        end
        check("held_input_no_valid", 64'(seen), 64'd0);

        repeat (200) begin
            int  r   = $urandom_range(0, 3);
            bit  clr = ($urandom_range(0, 7) == 0);
            case (r)
                0:       g = b2g(model_b + 1);
                1:       g = b2g(model_b + MOD - 1);
                2:       g = WIDTH'($urandom_range(0, MOD - 1));
                default: g = cur_g;
            endcase
            apply(g, clr);
        end

        do_reset(cur_g ^ 4'b0100);
        repeat (10) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
